// File: rtl/cp0_reg_pkg.sv
// Shared constants for the coprocessor-0 register file: register numbers,
// exception type codes, the writable-Cause mask and the ExcCode decoder.
package cp0_reg_pkg;

  // CP0 register numbers as seen by MTC0/MFC0
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  // Exception type codes delivered by the MEM stage
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_OV        = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  // Cause bits that software may write: IV[23], WP[22], IP[9:8]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  // Result of decoding an exception type: whether it traps, and its ExcCode
  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } exc_dec_t;

  // Map an exception type to its ExcCode; ERET and unknown types do not trap
  function automatic exc_dec_t exc_decode(input logic [31:0] et);
    exc_dec_t r;
    r.hit  = 1'b1;
    r.code = 5'd0;
    case (et)
      EXC_INTERRUPT: r.code = 5'd0;
      EXC_SYSCALL:   r.code = 5'd8;
      EXC_INST_INV:  r.code = 5'd10;
      EXC_TRAP:      r.code = 5'd13;
      EXC_OV:        r.code = 5'd12;
      default:       r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file at the write-back end of the pipeline.
// Commits MTC0 writes, runs Count/Compare, samples interrupt lines into
// Cause.IP[7:2], records exceptions and serves combinational MFC0 reads.
// Update priority within a cycle: increment < interrupt sample < timer
// match < MTC0 write < exception.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic        timer_q,   timer_d;
  exc_dec_t    exc_s;

  assign exc_s = exc_decode(excepttype_i);

  // Next-state: apply the per-cycle updates in increasing priority order
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q;

    cause_d[15:10] = int_i;

    // Match is against the pre-increment count; a zero Compare never fires
    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end else begin
      timer_d = timer_q;
    end

    if (we_i) begin
      case (waddr_i)
        CP0_REG_COUNT:   count_d = data_i;
        CP0_REG_COMPARE: begin
          compare_d = data_i;
          timer_d   = 1'b0;
        end
        CP0_REG_STATUS:  status_d = data_i;
        CP0_REG_EPC:     epc_d = data_i;
        CP0_REG_CAUSE:   cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        default:         count_d = count_d;
      endcase
    end else begin
      count_d = count_d;
    end

    // Nested exceptions (EXL already set) keep the original EPC and BD
    if (excepttype_i == EXC_ERET) begin
      status_d[1] = 1'b0;
    end else if (exc_s.hit) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end else begin
        cause_d[31] = cause_d[31];
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_s.code;
    end else begin
      status_d = status_d;
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RST;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  // MFC0 read mux over current register contents; no write bypass
  always_comb begin
    data_o = 32'd0;
    if (rst) begin
      data_o = 32'd0;
    end else begin
      case (raddr_i)
        CP0_REG_COUNT:   data_o = count_q;
        CP0_REG_COMPARE: data_o = compare_q;
        CP0_REG_STATUS:  data_o = status_q;
        CP0_REG_CAUSE:   data_o = cause_q;
        CP0_REG_EPC:     data_o = epc_q;
        CP0_REG_PRID:    data_o = PRID_VAL;
        CP0_REG_CONFIG:  data_o = CONFIG_VAL;
        default:         data_o = 32'd0;
      endcase
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_q;

endmodule
